jk_count_ctrl: RTL and testbench

- Sequencing controller for a bank of JK flip-flops that together form a WIDTH-bit programmable counter.
- Each cycle it generates the per-bit J/K excitation for load, hold, count-up or count-down, and compares the bank state against a terminal value.
- A small FSM with a start/stop/done handshake decides which excitation is applied.
- Sits between the control logic and the JK storage bank; it is the standard way to turn the team's JK flip-flops into a usable counter.

---
 rtl/jk_pkg.sv | 19 +
 rtl/jk_cell_rst.sv | 24 ++
 rtl/jk_count_ctrl.sv | 146 ++++++++++++++
 tb/tb_jk_count_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared encodings for the JK counter controller: FSM states and the
// excitation modes applied to the JK bank.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        LOAD   = 3'd1,
        CNT_UP = 3'd2,
        CNT_DN = 3'd3,
        RELOAD = 3'd4
    } exc_t;

endpackage

// File: rtl/jk_cell_rst.sv
// Single JK flip-flop with synchronous active-high reset to 0.
module jk_cell_rst (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // Classic JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_count_ctrl.sv
// Sequencing controller for a bank of JK flip-flops forming a WIDTH-bit
// programmable counter: start/stop/done FSM, excitation mux and terminal
// count compare. The bank is the only holder of the counter value.
module jk_count_ctrl
    import jk_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    input  logic             up_dn,
    input  logic             one_shot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_bus,
    output logic [WIDTH-1:0] k_bus,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    state_t           state;
    exc_t             mode;
    logic [WIDTH-1:0] base;
    logic             mode_os;

    // Toggle mask for counting up: bit i toggles when all lower bits are 1.
    function automatic logic [WIDTH-1:0] up_mask(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        logic             c;
        c = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            m[i] = c;
            c    = c & v[i];
        end
        return m;
    endfunction

    // Counting down toggles bit i when all lower bits are 0.
    function automatic logic [WIDTH-1:0] dn_mask(input logic [WIDTH-1:0] v);
        return up_mask(~v);
    endfunction

    // Terminal-count compare and excitation-mode selection (stop outranks tc).
    always_comb begin
        tc   = (state == RUN) && (q == term_val) && !stop;
        mode = HOLD;
        case (state)
            IDLE: begin
                if (load) mode = LOAD;
            end
            RUN: begin
                if (stop)       mode = HOLD;
                else if (tc)    mode = RELOAD;
                else if (up_dn) mode = CNT_UP;
                else            mode = CNT_DN;
            end
            default: mode = HOLD;
        endcase
    end

    // Per-bit J/K excitation driven into the bank for the selected mode.
    always_comb begin
        j_bus = '0;
        k_bus = '0;
        case (mode)
            LOAD: begin
                j_bus = load_val;
                k_bus = ~load_val;
            end
            RELOAD: begin
                j_bus = base;
                k_bus = ~base;
            end
            CNT_UP: begin
                j_bus = up_mask(q);
                k_bus = up_mask(q);
            end
            CNT_DN: begin
                j_bus = dn_mask(q);
                k_bus = dn_mask(q);
            end
            default: begin
                j_bus = '0;
                k_bus = '0;
            end
        endcase
    end

    // Control FSM with registered busy/done; base and run mode latched at start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            base    <= '0;
            mode_os <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        base    <= load ? load_val : q;
                        mode_os <= one_shot;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (tc && mode_os) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The JK storage bank: one cell per counter bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell_rst u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_bus[i]),
            .k   (k_bus[i]),
            .q   (q[i])
        );
    end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Scoreboard bench for jk_count_ctrl (WIDTH=4): the driver pushes the
// hand-computed expected outputs for each cycle; the monitor pops and
// compares on the falling edge.
module tb_jk_count_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, load, up_dn, one_shot;
    logic [3:0] load_val, term_val;
    logic [3:0] q, j_bus, k_bus;
    logic       busy, tc, done;

    typedef struct {
        logic [3:0] q;
        logic [3:0] j;
        logic [3:0] k;
        logic       busy;
        logic       done;
        logic       tc;
        logic       chkjk;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    jk_count_ctrl #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .load_val (load_val),
        .term_val (term_val),
        .up_dn    (up_dn),
        .one_shot (one_shot),
        .q        (q),
        .j_bus    (j_bus),
        .k_bus    (k_bus),
        .busy     (busy),
        .tc       (tc),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input int id, input string nm, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL step%0d %s: got %h expected %h", id, nm, got, want);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.id, "q",    q,        e.q);
            chk(e.id, "busy", 4'(busy), 4'(e.busy));
            chk(e.id, "done", 4'(done), 4'(e.done));
            chk(e.id, "tc",   4'(tc),   4'(e.tc));
            if (e.chkjk) begin
                chk(e.id, "j_bus", j_bus, e.j);
                chk(e.id, "k_bus", k_bus, e.k);
            end
        end
    end

    // Apply one cycle of inputs and queue the outputs expected during it.
    task automatic cyc(input logic r, input logic st, input logic sp, input logic ld,
                       input logic [3:0] lv, input logic [3:0] tv, input logic ud, input logic os,
                       input logic [3:0] eq, input logic eb, input logic ed, input logic et,
                       input logic cj, input logic [3:0] ej, input logic [3:0] ek);
        exp_t e;
        rst = r; start = st; stop = sp; load = ld;
        load_val = lv; term_val = tv; up_dn = ud; one_shot = os;
        step_id++;
        e.q = eq; e.j = ej; e.k = ek;
        e.busy = eb; e.done = ed; e.tc = et; e.chkjk = cj; e.id = step_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset cycle 1: state unknown before the first edge, nothing checked.
        rst = 1'b1; start = 1'($urandom); stop = 1'($urandom); load = 1'($urandom);
        load_val = 4'($urandom); term_val = 4'($urandom);
        up_dn = 1'($urandom); one_shot = 1'($urandom);
        @(posedge clk);
        #1;
        // Reset cycle 2 with random inputs: control outputs must be cleared.
        cyc(1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 4'h0, 0, 0, 0, 0, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0, 0, 1, 4'h0, 4'h0);

        // Load 5 in IDLE.
        cyc(0, 0, 0, 1, 4'h5, 4'h0, 0, 0,  4'h0, 0, 0, 0, 1, 4'h5, 4'hA);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h5, 0, 0, 0, 1, 4'h0, 4'h0);

        // One-shot up run 5 -> 9, reload to 5, done pulse.
        cyc(0, 1, 0, 0, 4'h0, 4'h9, 1, 1,  4'h5, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h5, 1, 0, 0, 1, 4'h3, 4'h3);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h6, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h7, 1, 0, 0, 1, 4'hF, 4'hF);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h8, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h9, 1, 0, 1, 1, 4'h5, 4'hA);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h5, 0, 1, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h9, 1, 0,  4'h5, 0, 0, 0, 1, 4'h0, 4'h0);

        // Continuous down run from 2 with wrap, reload at 14, then stop.
        cyc(0, 0, 0, 1, 4'h2, 4'h0, 0, 0,  4'h5, 0, 0, 0, 1, 4'h2, 4'hD);
        cyc(0, 1, 0, 0, 4'h0, 4'hE, 0, 0,  4'h2, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'h2, 1, 0, 0, 1, 4'h3, 4'h3);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'h1, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'h0, 1, 0, 0, 1, 4'hF, 4'hF);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'hF, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'hE, 1, 0, 1, 1, 4'h2, 4'hD);
        cyc(0, 0, 0, 0, 4'h0, 4'hE, 0, 0,  4'h2, 1, 0, 0, 1, 4'h3, 4'h3);
        cyc(0, 0, 1, 0, 4'h0, 4'hE, 0, 0,  4'h1, 1, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h1, 0, 0, 0, 1, 4'h0, 4'h0);

        // Load and start together (base 6), stop at 7.
        cyc(0, 1, 0, 1, 4'h6, 4'hF, 1, 1,  4'h1, 0, 0, 0, 1, 4'h6, 4'h9);
        cyc(0, 0, 0, 0, 4'h0, 4'hF, 1, 0,  4'h6, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 1, 0, 4'h0, 4'hF, 1, 0,  4'h7, 1, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h7, 0, 0, 0, 1, 4'h0, 4'h0);

        // Stop while q equals term_val: no tc, no reload.
        cyc(0, 1, 0, 0, 4'h0, 4'h8, 1, 1,  4'h7, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h8, 1, 0,  4'h7, 1, 0, 0, 1, 4'hF, 4'hF);
        cyc(0, 0, 1, 0, 4'h0, 4'h8, 1, 0,  4'h8, 1, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h8, 1, 0,  4'h8, 0, 0, 0, 1, 4'h0, 4'h0);

        // Reset mid-run at 8, then a one-shot run from base 0 to 3.
        cyc(0, 1, 0, 0, 4'h0, 4'hF, 1, 0,  4'h8, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(1, 0, 0, 0, 4'h0, 4'hF, 1, 0,  4'h8, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h0, 0, 0,  4'h0, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 1, 0, 0, 4'h0, 4'h3, 1, 1,  4'h0, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h0, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h1, 1, 0, 0, 1, 4'h3, 4'h3);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h2, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h3, 1, 0, 1, 1, 4'h0, 4'hF);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h0, 0, 1, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h3, 1, 0,  4'h0, 0, 0, 0, 1, 4'h0, 4'h0);

        // Up wrap 14 -> 15 -> 0 -> 1 (terminal), start ignored in DONE.
        cyc(0, 0, 0, 1, 4'hE, 4'h0, 0, 0,  4'h0, 0, 0, 0, 1, 4'hE, 4'h1);
        cyc(0, 1, 0, 0, 4'h0, 4'h1, 1, 1,  4'hE, 0, 0, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h1, 1, 0,  4'hE, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h1, 1, 0,  4'hF, 1, 0, 0, 1, 4'hF, 4'hF);
        cyc(0, 0, 0, 0, 4'h0, 4'h1, 1, 0,  4'h0, 1, 0, 0, 1, 4'h1, 4'h1);
        cyc(0, 0, 0, 0, 4'h0, 4'h1, 1, 0,  4'h1, 1, 0, 1, 1, 4'hE, 4'h1);
        cyc(0, 1, 0, 0, 4'h0, 4'h1, 1, 1,  4'hE, 0, 1, 0, 1, 4'h0, 4'h0);
        cyc(0, 0, 0, 0, 4'h0, 4'h1, 1, 0,  4'hE, 0, 0, 0, 1, 4'h0, 4'h0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
